// File: rtl/ex_regincr_pkg.sv
// Shared definitions for the registered +2 incrementer datapath and its output queue.
package ex_regincr_pkg;

    localparam int REGINCR_NBITS = 8;

    typedef logic [REGINCR_NBITS-1:0] regincr_word_t;

endpackage

// File: rtl/ex_regincr_queue_ctrl.sv
// Control path of the output queue: pointers, occupancy, handshake fires and high-water mark.
module ex_regincr_queue_ctrl #(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          enq_val,
    input  logic          deq_rdy,
    output logic          enq_rdy,
    output logic          deq_val,
    output logic          enq_fire,
    output logic          deq_fire,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic [CW-1:0] high_water
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [CW-1:0] count_next;
    logic [CW-1:0] high_water_next;

    // Ready/valid come only from registered occupancy, so neither side sees the other's request.
    always_comb begin
        enq_rdy  = (count != FULL_COUNT);
        deq_val  = (count != '0);
        enq_fire = enq_val && enq_rdy;
        deq_fire = deq_val && deq_rdy;

        count_next = count;
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase

        high_water_next = (count_next > high_water) ? count_next : high_water;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            high_water <= '0;
        end else begin
            if (enq_fire) wr_ptr <= wr_ptr + 1'b1;
            if (deq_fire) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            high_water <= high_water_next;
        end
    end

endmodule

// File: rtl/ex_regincr_output_queue.sv
// Circular FIFO buffering incrementer results onto a val/rdy interface, with occupancy tracking.
module ex_regincr_output_queue
    import ex_regincr_pkg::*;
#(
    parameter  int NBITS = REGINCR_NBITS,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enq_val,
    output logic             enq_rdy,
    input  logic [NBITS-1:0] enq_msg,
    output logic             deq_val,
    input  logic             deq_rdy,
    output logic [NBITS-1:0] deq_msg,
    output logic [CW-1:0]    num_entries,
    output logic [CW-1:0]    high_water
);

    logic          enq_fire;
    logic          deq_fire;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [NBITS-1:0] mem [DEPTH];

    ex_regincr_queue_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .enq_val    (enq_val),
        .deq_rdy    (deq_rdy),
        .enq_rdy    (enq_rdy),
        .deq_val    (deq_val),
        .enq_fire   (enq_fire),
        .deq_fire   (deq_fire),
        .wr_ptr     (wr_ptr),
        .rd_ptr     (rd_ptr),
        .count      (count),
        .high_water (high_water)
    );

    // Storage is deliberately unreset; deq_val masks stale contents.
    always_ff @(posedge clk) begin
        if (enq_fire) mem[wr_ptr] <= enq_msg;
    end

    assign deq_msg     = mem[rd_ptr];
    assign num_entries = count;

endmodule

// File: tb/tb_ex_regincr_output_queue.sv
// Directed and randomized-stall checks of the incrementer output queue.
module tb_ex_regincr_output_queue;
    import ex_regincr_pkg::*;

    logic          clk;
    logic          reset_n;
    logic          enq_val;
    logic          enq_rdy;
    regincr_word_t enq_msg;
    logic          deq_val;
    logic          deq_rdy;
    regincr_word_t deq_msg;
    logic [2:0]    num_entries;
    logic [2:0]    high_water;

    int vectors;
    int miscompares;

    ex_regincr_output_queue #(
        .NBITS (REGINCR_NBITS),
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enq_val     (enq_val),
        .enq_rdy     (enq_rdy),
        .enq_msg     (enq_msg),
        .deq_val     (deq_val),
        .deq_rdy     (deq_rdy),
        .deq_msg     (deq_msg),
        .num_entries (num_entries),
        .high_water  (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        regincr_word_t q[$];
        int sent;
        int recvd;
        int m_hw;
        int cyc;
        logic e_fire;
        logic d_fire;
        regincr_word_t exp_w;

        vectors     = 0;
        miscompares = 0;
        reset_n = 1'b0;
        enq_val = 1'b0;
        deq_rdy = 1'b0;
        enq_msg = '0;

        // Reset state
        tick; tick;
        chk("rst_enq_rdy", 32'(enq_rdy), 32'd1);
        chk("rst_deq_val", 32'(deq_val), 32'd0);
        chk("rst_num", 32'(num_entries), 32'd0);
        chk("rst_hw", 32'(high_water), 32'd0);
        reset_n = 1'b1;
        tick;

        // Single pass, no bypass
        enq_val = 1'b1; enq_msg = 8'h05; deq_rdy = 1'b1;
        chk("sp_no_bypass", 32'(deq_val), 32'd0);
        tick;
        enq_val = 1'b0;
        chk("sp_deq_val", 32'(deq_val), 32'd1);
        chk("sp_deq_msg", 32'(deq_msg), 32'h05);
        chk("sp_num1", 32'(num_entries), 32'd1);
        tick;
        chk("sp_empty", 32'(deq_val), 32'd0);
        chk("sp_num0", 32'(num_entries), 32'd0);
        chk("sp_hw", 32'(high_water), 32'd1);

        // Fill with consumer stalled
        deq_rdy = 1'b0;
        for (int v = 2; v <= 5; v++) begin
            enq_val = 1'b1; enq_msg = regincr_word_t'(v);
            tick;
            chk("fill_num", 32'(num_entries), 32'(v - 1));
        end
        chk("full_enq_rdy", 32'(enq_rdy), 32'd0);
        chk("full_hw", 32'(high_water), 32'd4);
        enq_msg = 8'h06;
        tick;
        chk("holdoff_num", 32'(num_entries), 32'd4);
        chk("holdoff_head", 32'(deq_msg), 32'h02);

        // Full with both sides requesting: only the dequeue fires
        deq_rdy = 1'b1;
        tick;
        chk("fs_num", 32'(num_entries), 32'd3);
        chk("fs_enq_rdy", 32'(enq_rdy), 32'd1);
        chk("fs_head", 32'(deq_msg), 32'h03);
        tick;
        enq_val = 1'b0;
        chk("fs_enq_then_num", 32'(num_entries), 32'd3);
        for (int v = 4; v <= 6; v++) begin
            chk("drain_msg", 32'(deq_msg), 32'(v));
            tick;
        end
        chk("drain_empty", 32'(deq_val), 32'd0);
        chk("drain_num", 32'(num_entries), 32'd0);

        // Streaming with pointer wrap
        deq_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            enq_val = 1'b1; enq_msg = regincr_word_t'(i);
            tick;
            chk("stream_msg", 32'(deq_msg), 32'(i));
            chk("stream_num", 32'(num_entries), 32'd1);
        end
        enq_val = 1'b0;
        tick;
        chk("stream_end", 32'(num_entries), 32'd0);
        chk("stream_hw", 32'(high_water), 32'd4);

        // Async reset with three entries queued
        deq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq_val = 1'b1; enq_msg = regincr_word_t'(8'hA0 + i);
            tick;
        end
        enq_val = 1'b0;
        chk("pre_rst_num", 32'(num_entries), 32'd3);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_num", 32'(num_entries), 32'd0);
        chk("arst_deq_val", 32'(deq_val), 32'd0);
        chk("arst_enq_rdy", 32'(enq_rdy), 32'd1);
        chk("arst_hw", 32'(high_water), 32'd0);
        tick;
        reset_n = 1'b1;
        tick;
        chk("post_rst_num", 32'(num_entries), 32'd0);

        // Random stalls against a queue model
        sent  = 0;
        recvd = 0;
        m_hw  = 0;
        cyc   = 0;
        while (recvd < 200 && cyc < 4000) begin
            enq_val = (sent < 200) && ($urandom_range(0, 9) < 7);
            enq_msg = regincr_word_t'($urandom_range(0, 255));
            deq_rdy = ($urandom_range(0, 1) == 1);
            #1;
            chk("rnd_enq_rdy", 32'(enq_rdy), 32'(q.size() != 4));
            chk("rnd_deq_val", 32'(deq_val), 32'(q.size() != 0));
            e_fire = enq_val && (q.size() != 4);
            d_fire = deq_rdy && (q.size() != 0);
            if (d_fire) begin
                exp_w = q.pop_front();
                chk("rnd_deq_msg", 32'(deq_msg), 32'(exp_w));
                recvd++;
            end
            if (e_fire) begin
                q.push_back(enq_msg);
                sent++;
            end
            if (q.size() > m_hw) m_hw = q.size();
            tick;
            chk("rnd_num", 32'(num_entries), 32'(q.size()));
            chk("rnd_hw", 32'(high_water), 32'(m_hw));
            cyc++;
        end
        chk("rnd_done", 32'(recvd), 32'd200);
        chk("rnd_hw_bound", 32'(high_water <= 3'd4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
